// File: rtl/dpwm_duty_sched.sv
// DPWM duty scheduler: shadows strobed duty words and commits them only at period boundaries.
// Latency: commit at the next counter wrap while running, or on the next edge while stopped; ack follows for one cycle.
// Backpressure: none; strobes arriving while an update is pending overwrite the shadow, last write wins.
module dpwm_duty_sched #(
    parameter int WIDTH  = 8,
    parameter int PERIOD = 255,
    parameter int DMIN   = 0,
    parameter int DMAX   = 255
) (
    input  logic             clkm,
    input  logic             reset,
    input  logic             enable,
    input  logic             dato,
    input  logic [WIDTH-1:0] duty_in,
    output logic             pwm,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             ack
);

    localparam logic [WIDTH-1:0] PERIOD_W = WIDTH'(PERIOD);
    localparam logic [WIDTH-1:0] DMIN_W   = WIDTH'(DMIN);
    localparam logic [WIDTH-1:0] DMAX_W   = WIDTH'(DMAX);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    logic             run;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] shadow_nxt;
    logic [WIDTH-1:0] duty_act;
    logic [WIDTH-1:0] duty_nxt;
    logic             wrap;
    logic             evt;

    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] x);
        if (x < DMIN_W)
            return DMIN_W;
        else if (x > DMAX_W)
            return DMAX_W;
        else
            return x;
    endfunction

    assign wrap = run && (cnt == PERIOD_W);
    // A stopped counter has no period to protect, so any edge is a legal commit point.
    assign evt  = run ? wrap : 1'b1;

    assign pwm  = run && (cnt < duty_act);
    assign busy = (state != ST_IDLE);
    assign ack  = (state == ST_ACK);

    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        duty_nxt   = duty_act;
        case (state)
            ST_IDLE: begin
                if (dato) begin
                    shadow_nxt = duty_in;
                    state_nxt  = ST_PEND;
                end
            end
            ST_PEND: begin
                if (evt) begin
                    state_nxt = ST_ACK;
                    if (dato) begin
                        shadow_nxt = duty_in;
                        duty_nxt   = clamp(duty_in);
                    end else begin
                        duty_nxt   = clamp(shadow);
                    end
                end else if (dato) begin
                    shadow_nxt = duty_in;
                end
            end
            ST_ACK: begin
                if (dato) begin
                    shadow_nxt = duty_in;
                    state_nxt  = ST_PEND;
                end else begin
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkm or posedge reset) begin
        if (reset) begin
            run      <= 1'b0;
            cnt      <= '0;
            state    <= ST_IDLE;
            shadow   <= '0;
            duty_act <= DMIN_W;
        end else begin
            run      <= enable;
            cnt      <= run ? (wrap ? '0 : cnt + WIDTH'(1)) : '0;
            state    <= state_nxt;
            shadow   <= shadow_nxt;
            duty_act <= duty_nxt;
        end
    end

endmodule

// File: tb/tb_dpwm_duty_sched.sv
// Bench for dpwm_duty_sched: directed period-level checks plus randomized traffic against a behavioural model.
module tb_dpwm_duty_sched;

    localparam int WIDTH  = 4;
    localparam int PERIOD = 9;
    localparam int DMIN   = 1;
    localparam int DMAX   = 8;

    logic             clkm = 1'b0;
    logic             reset = 1'b0;
    logic             enable = 1'b0;
    logic             dato = 1'b0;
    logic [WIDTH-1:0] duty_in = '0;
    logic             pwm;
    logic [WIDTH-1:0] cnt;
    logic             busy;
    logic             ack;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    dpwm_duty_sched #(
        .WIDTH (WIDTH),
        .PERIOD(PERIOD),
        .DMIN  (DMIN),
        .DMAX  (DMAX)
    ) dut (
        .clkm   (clkm),
        .reset  (reset),
        .enable (enable),
        .dato   (dato),
        .duty_in(duty_in),
        .pwm    (pwm),
        .cnt    (cnt),
        .busy   (busy),
        .ack    (ack)
    );

    always #5 clkm = ~clkm;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a pending flag plus an ack flag, stepped once per clock edge.
    bit m_run, m_pend, m_ackf;
    int m_cnt, m_duty, m_shadow;

    function automatic int clampf(input int x);
        return (x < DMIN) ? DMIN : ((x > DMAX) ? DMAX : x);
    endfunction

    always @(posedge clkm or posedge reset) begin
        bit ev;
        int nc;
        if (reset) begin
            m_run = 0; m_pend = 0; m_ackf = 0;
            m_cnt = 0; m_shadow = 0; m_duty = clampf(0);
        end else begin
            ev = m_run ? (m_cnt == PERIOD) : 1'b1;
            nc = m_run ? (m_cnt + 1) % (PERIOD + 1) : 0;
            if (m_ackf) begin
                m_ackf = 0;
                if (dato) begin m_pend = 1; m_shadow = int'(duty_in); end
            end else if (m_pend) begin
                if (dato) m_shadow = int'(duty_in);
                if (ev) begin
                    m_duty = clampf(m_shadow);
                    m_pend = 0;
                    m_ackf = 1;
                end
            end else if (dato) begin
                m_pend = 1;
                m_shadow = int'(duty_in);
            end
            m_run = enable;
            m_cnt = nc;
        end
    end

    always @(negedge clkm) begin
        if (chk_en && !reset) begin
            chk("model_cnt", cnt, m_cnt);
            chk("model_pwm", pwm, (m_run && (m_cnt < m_duty)) ? 1 : 0);
            chk("model_busy", busy, (m_pend || m_ackf) ? 1 : 0);
            chk("model_ack", ack, m_ackf ? 1 : 0);
        end
    end

    task automatic tick();
        @(posedge clkm);
        #1;
    endtask

    task automatic wait_cnt(input int k);
        int n = 0;
        while (cnt !== k[WIDTH-1:0] && n < 3 * (PERIOD + 1)) begin
            tick();
            n++;
        end
        chk("wait_cnt", cnt, k);
    endtask

    task automatic strobe(input int d);
        dato = 1'b1;
        duty_in = d[WIDTH-1:0];
        tick();
        dato = 1'b0;
    endtask

    // Walks one period from cnt=0, checking the pwm shape; returns how many ack cycles were seen.
    task automatic check_period(input string nm, input int d, output int acks);
        acks = 0;
        for (int i = 0; i <= PERIOD; i++) begin
            chk(nm, pwm, (i < d) ? 1 : 0);
            chk({nm, "_cnt"}, cnt, i);
            acks += int'(ack);
            tick();
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_pwm"}, pwm, 0);
        chk({nm, "_cnt"}, cnt, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_ack"}, ack, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        reset = 1'b1;
        chk_en = 1'b1;
        repeat (3) tick();
        #2 reset = 1'b0;
        enable = 1'b1;
        repeat (6) tick();
        strobe(3);
        chk("pre_reset_busy", busy, 1);
        #2 reset = 1'b1;
        #1 check_reset_outputs("async_reset");
        @(posedge clkm);
        #3 reset = 1'b0;
        tick();

        // Idle pattern with duty at the lower clamp
        wait_cnt(0);
        check_period("idle_pwm", 1, acks);
        chk("idle_acks", acks, 0);

        // Running update
        wait_cnt(3);
        strobe(5);
        chk("upd_busy", busy, 1);
        chk("upd_ack_early", ack, 0);
        wait_cnt(0);
        chk("upd_ack", ack, 1);
        check_period("upd_pwm", 5, acks);
        chk("upd_acks", acks, 1);
        chk("upd_busy_after", busy, 0);

        // Merge and clamp high
        wait_cnt(2);
        strobe(3);
        wait_cnt(6);
        strobe(15);
        wait_cnt(0);
        chk("merge_ack", ack, 1);
        check_period("merge_pwm", 8, acks);
        chk("merge_acks", acks, 1);

        // Clamp low
        wait_cnt(4);
        strobe(0);
        wait_cnt(0);
        check_period("clamp0_pwm", 1, acks);
        chk("clamp0_acks", acks, 1);

        // Strobe in the terminal cycle while pending: newest value commits at that wrap
        wait_cnt(5);
        strobe(4);
        wait_cnt(9);
        strobe(6);
        chk("simul_ack", ack, 1);
        check_period("simul_pwm", 6, acks);
        chk("simul_acks", acks, 1);

        // Strobe in the terminal cycle while idle: deferred one full period
        wait_cnt(9);
        strobe(2);
        chk("defer_busy", busy, 1);
        check_period("defer_old_pwm", 6, acks);
        chk("defer_no_ack", acks, 0);
        chk("defer_ack", ack, 1);
        check_period("defer_new_pwm", 2, acks);
        chk("defer_acks", acks, 1);

        // Stopped configuration
        enable = 1'b0;
        repeat (3) tick();
        chk("stop_cnt", cnt, 0);
        chk("stop_pwm", pwm, 0);
        strobe(7);
        chk("stop_busy", busy, 1);
        chk("stop_ack_early", ack, 0);
        tick();
        chk("stop_ack", ack, 1);
        chk("stop_pwm_ack", pwm, 0);
        chk("stop_cnt_ack", cnt, 0);
        tick();
        chk("stop_ack_end", ack, 0);
        chk("stop_busy_end", busy, 0);
        enable = 1'b1;
        tick();
        check_period("start_pwm", 7, acks);
        chk("start_acks", acks, 0);

        // Reset in the middle of a pending update
        wait_cnt(2);
        strobe(6);
        tick();
        chk("rmid_busy", busy, 1);
        #2 reset = 1'b1;
        #1 check_reset_outputs("rmid_reset");
        @(posedge clkm);
        #3 reset = 1'b0;
        tick();
        acks = 0;
        for (int i = 0; i < 25; i++) begin
            acks += int'(ack);
            tick();
        end
        chk("rmid_no_ack", acks, 0);
        wait_cnt(0);
        chk("rmid_busy_after", busy, 0);
        check_period("rmid_pwm", 1, acks);

        // Randomized traffic, checked every cycle by the model compare process
        for (int i = 0; i < 600; i++) begin
            enable  = ($urandom_range(0, 24) != 0);
            dato    = ($urandom_range(0, 5) == 0);
            duty_in = WIDTH'($urandom_range(0, 15));
            tick();
        end
        dato = 1'b0;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
